// File: rtl/apu_reg_writer.sv
// CPU-side write buffer for the APU $4000-$4017 register window: queues byte
// writes and commits them one at a time with a programmable minimum spacing.
module apu_reg_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int WRITE_GAP  = 1
) (
    input  logic         iClk,
    input  logic         iReset,
    input  logic [4:0]   iAddr,
    input  logic [7:0]   iData,
    input  logic         iValid,
    output logic         oReady,
    output logic [191:0] oRegisters,
    output logic [23:0]  oW,
    output logic         oBusy,
    output logic [7:0]   oDropCount
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int GW = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(WRITE_GAP - 1);

    logic [4:0]    fifo_addr [FIFO_DEPTH];
    logic [7:0]    fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [GW-1:0] gap_cnt;
    logic          empty;
    logic          full_nxt;
    logic          push;
    logic          pop;
    logic [4:0]    head_addr;
    logic [7:0]    head_data;

    function automatic logic is_mapped(input logic [4:0] a);
        case (a)
            5'h09, 5'h0D, 5'h14, 5'h16: is_mapped = 1'b0;
            default:                    is_mapped = (a <= 5'h17);
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign empty      = (wr_ptr == rd_ptr);
    assign push       = iValid && oReady;
    assign pop        = !empty && (gap_cnt == '0);
    assign wr_ptr_nxt = wr_ptr + PW'(push);
    assign rd_ptr_nxt = rd_ptr + PW'(pop);
    // Extra pointer bit separates full (MSBs differ) from empty (MSBs equal).
    assign full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                        (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    assign head_addr  = fifo_addr[rd_ptr[AW-1:0]];
    assign head_data  = fifo_data[rd_ptr[AW-1:0]];
    assign oBusy      = !empty || (gap_cnt != '0);

    always_ff @(posedge iClk) begin
        if (push) begin
            fifo_addr[wr_ptr[AW-1:0]] <= iAddr;
            fifo_data[wr_ptr[AW-1:0]] <= iData;
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            gap_cnt    <= '0;
            oReady     <= 1'b1;
            oW         <= '0;
            oDropCount <= '0;
            oRegisters <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            oReady <= !full_nxt;
            oW     <= '0;
            if (pop) begin
                gap_cnt <= GAP_LOAD;
                if (is_mapped(head_addr)) begin
                    for (int k = 0; k < 24; k++) begin
                        if (head_addr == 5'(k)) begin
                            oRegisters[8*k +: 8] <= head_data;
                            oW[k]                <= 1'b1;
                        end
                    end
                end else begin
                    oDropCount <= sat_inc(oDropCount);
                end
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end
endmodule

// File: tb/tb_apu_reg_writer.sv
// Bench for apu_reg_writer: two instances (WRITE_GAP 1 and 4) checked every
// cycle against a queue-based model, plus directed literal expectations.
module tb_apu_reg_writer;
    logic         iClk = 1'b0;
    logic         rst;
    logic [4:0]   addr;
    logic [7:0]   data;
    logic         vld0, vld1;
    logic         rdy0, rdy1, busy0, busy1;
    logic [191:0] regs0, regs1;
    logic [23:0]  w0, w1;
    logic [7:0]   drop0, drop1;

    always #5 iClk = ~iClk;

    apu_reg_writer #(.FIFO_DEPTH(4), .WRITE_GAP(1)) dut0 (
        .iClk(iClk), .iReset(rst), .iAddr(addr), .iData(data), .iValid(vld0),
        .oReady(rdy0), .oRegisters(regs0), .oW(w0), .oBusy(busy0), .oDropCount(drop0)
    );
    apu_reg_writer #(.FIFO_DEPTH(4), .WRITE_GAP(4)) dut1 (
        .iClk(iClk), .iReset(rst), .iAddr(addr), .iData(data), .iValid(vld1),
        .oReady(rdy1), .oRegisters(regs1), .oW(w1), .oBusy(busy1), .oDropCount(drop1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: pending writes as an ordered list, a countdown until
    // the next commit is allowed, and the resulting register image.
    int          m_cnt [2];
    int          m_gap [2];
    int          m_drop [2];
    logic [23:0] m_w [2];
    logic [7:0]  m_reg [2][24];
    logic [4:0]  m_qa [2][4];
    logic [7:0]  m_qd [2][4];
    bit          m_on = 0;
    int          cyc = 0;

    function automatic bit mapped_m(input int a);
        return (a < 24) && (a != 9) && (a != 13) && (a != 20) && (a != 22);
    endfunction

    initial begin
        forever begin
            @(posedge iClk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                bit v, commit, accept;
                int g, a;
                v = (i == 0) ? vld0 : vld1;
                g = (i == 0) ? 1 : 4;
                if (rst) begin
                    m_cnt[i] = 0; m_gap[i] = 0; m_drop[i] = 0; m_w[i] = '0;
                    for (int k = 0; k < 24; k++) m_reg[i][k] = 8'h00;
                end else begin
                    commit = (m_cnt[i] > 0) && (m_gap[i] == 0);
                    accept = v && (m_cnt[i] < 4);
                    m_w[i] = '0;
                    if (commit) begin
                        a = int'(m_qa[i][0]);
                        if (mapped_m(a)) begin
                            m_reg[i][a] = m_qd[i][0];
                            m_w[i][a]   = 1'b1;
                        end else if (m_drop[i] < 255) begin
                            m_drop[i]++;
                        end
                        for (int j = 0; j < 3; j++) begin
                            m_qa[i][j] = m_qa[i][j+1];
                            m_qd[i][j] = m_qd[i][j+1];
                        end
                        m_cnt[i]--;
                        m_gap[i] = g - 1;
                    end else if (m_gap[i] > 0) begin
                        m_gap[i]--;
                    end
                    if (accept) begin
                        m_qa[i][m_cnt[i]] = addr;
                        m_qd[i][m_cnt[i]] = data;
                        m_cnt[i]++;
                    end
                end
            end
            if (rst) m_on = 1;
        end
    end

    int ev_idx0 [$], ev_cyc0 [$], ev_idx1 [$], ev_cyc1 [$];
    bit seen_full1 = 0;

    initial begin
        forever begin
            @(negedge iClk);
            if (m_on) begin
                for (int i = 0; i < 2; i++) begin
                    logic [191:0] exp_regs, a_regs;
                    logic [23:0]  a_w;
                    logic         a_rdy, a_busy;
                    logic [7:0]   a_drop;
                    for (int k = 0; k < 24; k++) exp_regs[8*k +: 8] = m_reg[i][k];
                    a_regs = (i == 0) ? regs0 : regs1;
                    a_w    = (i == 0) ? w0 : w1;
                    a_rdy  = (i == 0) ? rdy0 : rdy1;
                    a_busy = (i == 0) ? busy0 : busy1;
                    a_drop = (i == 0) ? drop0 : drop1;
                    chk($sformatf("dut%0d oW cyc%0d", i, cyc), 192'(a_w), 192'(m_w[i]));
                    chk($sformatf("dut%0d oRegisters cyc%0d", i, cyc), a_regs, exp_regs);
                    chk($sformatf("dut%0d oReady cyc%0d", i, cyc), 192'(a_rdy), 192'(m_cnt[i] < 4));
                    chk($sformatf("dut%0d oBusy cyc%0d", i, cyc), 192'(a_busy),
                        192'((m_cnt[i] > 0) || (m_gap[i] > 0)));
                    chk($sformatf("dut%0d oDropCount cyc%0d", i, cyc), 192'(a_drop), 192'(m_drop[i]));
                    for (int k = 0; k < 24; k++) begin
                        if (a_w[k]) begin
                            if (i == 0) begin ev_idx0.push_back(k); ev_cyc0.push_back(cyc); end
                            else begin ev_idx1.push_back(k); ev_cyc1.push_back(cyc); end
                        end
                    end
                    if (i == 1 && a_rdy === 1'b0) seen_full1 = 1;
                end
            end
        end
    end

    // Drive one write on the selected instance; returns at the negedge after acceptance.
    task automatic put(input int sel, input logic [4:0] a, input logic [7:0] d);
        int guard;
        guard = 0;
        addr = a;
        data = d;
        if (sel == 0) vld0 = 1'b1; else vld1 = 1'b1;
        while ((((sel == 0) ? rdy0 : rdy1) !== 1'b1) && guard < 50) begin
            @(negedge iClk);
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL put_timeout dut%0d: oReady stayed low, required high", sel);
        end
        @(negedge iClk);
    endtask

    task automatic idle();
        vld0 = 1'b0;
        vld1 = 1'b0;
    endtask

    task automatic wait_idle(input int sel);
        int guard;
        guard = 0;
        while ((((sel == 0) ? busy0 : busy1) !== 1'b0) && guard < 100) begin
            @(negedge iClk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout dut%0d: oBusy stayed high, required low", sel);
        end
        @(negedge iClk);
        #1;
    endtask

    initial begin
        int b0, b1;
        rst = 1'b1; vld0 = 1'b0; vld1 = 1'b0; addr = '0; data = '0;
        repeat (2) @(negedge iClk);
        rst = 1'b0;
        chk("reset oReady", 192'(rdy0), 192'(1));
        chk("reset oBusy", 192'(busy0), 192'(0));
        chk("reset oRegisters", regs0, 192'(0));
        chk("reset oDropCount", 192'(drop1), 192'(0));

        // Single write: no bypass, strobe one cycle later, then idle.
        put(0, 5'h03, 8'hA5);
        idle();
        chk("single no_bypass oW", 192'(w0), 192'(0));
        @(negedge iClk);
        chk("single oW", 192'(w0), 192'(24'h000008));
        chk("single byte3", 192'(regs0[31:24]), 192'(8'hA5));
        @(negedge iClk);
        chk("single oW_cleared", 192'(w0), 192'(0));
        chk("single oBusy_low", 192'(busy0), 192'(0));

        // Held iValid, six writes, gap 1: consecutive in-order commits.
        b0 = ev_idx0.size();
        for (int i = 0; i < 6; i++) put(0, 5'(i), 8'(8'h10 + i));
        idle();
        wait_idle(0);
        chk("burst6 strobe_count", 192'(ev_idx0.size() - b0), 192'(6));
        for (int i = 0; i < 6 && b0 + i < ev_idx0.size(); i++) begin
            chk($sformatf("burst6 order%0d", i), 192'(ev_idx0[b0+i]), 192'(i));
            if (i > 0) chk($sformatf("burst6 spacing%0d", i),
                           192'(ev_cyc0[b0+i] - ev_cyc0[b0+i-1]), 192'(1));
        end
        chk("burst6 byte5", 192'(regs0[47:40]), 192'(8'h15));

        // Gap 4: two commits exactly four cycles apart.
        b1 = ev_idx1.size();
        put(1, 5'h15, 8'h0F);
        put(1, 5'h17, 8'hC0);
        idle();
        wait_idle(1);
        chk("gap4 strobe_count", 192'(ev_idx1.size() - b1), 192'(2));
        if (ev_idx1.size() >= b1 + 2)
            chk("gap4 spacing", 192'(ev_cyc1[b1+1] - ev_cyc1[b1]), 192'(4));
        chk("gap4 byte15", 192'(regs1[8*21 +: 8]), 192'(8'h0F));
        chk("gap4 byte17", 192'(regs1[8*23 +: 8]), 192'(8'hC0));

        // Gap 4 with six writes: the buffer fills and oReady drops.
        seen_full1 = 0;
        b1 = ev_idx1.size();
        for (int i = 0; i < 6; i++) put(1, 5'(i), 8'(8'h20 + i));
        idle();
        wait_idle(1);
        chk("fill ready_dropped", 192'(seen_full1), 192'(1));
        chk("fill strobe_count", 192'(ev_idx1.size() - b1), 192'(6));
        if (ev_idx1.size() >= b1 + 6)
            chk("fill last_order", 192'(ev_idx1[b1+5]), 192'(5));

        // Unmapped offsets: no strobes, drop counter counts and saturates.
        b0 = ev_idx0.size();
        put(0, 5'h09, 8'h11);
        put(0, 5'h16, 8'h22);
        put(0, 5'h1F, 8'h33);
        idle();
        wait_idle(0);
        chk("drop count3", 192'(drop0), 192'(3));
        chk("drop no_strobe", 192'(ev_idx0.size() - b0), 192'(0));
        chk("drop byte09_zero", 192'(regs0[8*9 +: 8]), 192'(0));
        for (int i = 0; i < 300; i++) put(0, 5'h18, 8'(i));
        idle();
        wait_idle(0);
        chk("drop saturate", 192'(drop0), 192'(255));

        // Repeated identical writes each strobe.
        b0 = ev_idx0.size();
        put(0, 5'h0B, 8'h08);
        put(0, 5'h0B, 8'h08);
        idle();
        wait_idle(0);
        chk("repeat strobe_count", 192'(ev_idx0.size() - b0), 192'(2));
        if (ev_idx0.size() >= b0 + 2)
            chk("repeat second_index", 192'(ev_idx0[b0+1]), 192'(11));
        chk("repeat byte0B", 192'(regs0[8*11 +: 8]), 192'(8'h08));

        // Reset with a loaded buffer discards everything.
        for (int i = 0; i < 4; i++) put(1, 5'(i), 8'(8'hE0 + i));
        idle();
        rst = 1'b1;
        @(negedge iClk);
        #1;
        rst = 1'b0;
        b0 = ev_idx0.size();
        b1 = ev_idx1.size();
        repeat (20) @(negedge iClk);
        #1;
        chk("midreset no_strobes", 192'(ev_idx1.size() - b1), 192'(0));
        chk("midreset no_strobes0", 192'(ev_idx0.size() - b0), 192'(0));
        chk("midreset oRegisters", regs1, 192'(0));
        chk("midreset oReady", 192'(rdy1), 192'(1));
        chk("midreset oBusy", 192'(busy1), 192'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
